register_file_sb: RTL and testbench

- Parametrised successor of the single-cycle integer register file, built for the pipelined core.
- Provides NRD combinational read ports with write-to-read bypass, one synchronous write port and a per-register busy scoreboard.
- Decode reads operands and busy flags; issue marks destinations pending; writeback commits data and clears pending.
- Sits between decode/hazard unit and writeback stage.

---
 rtl/register_file_sb_pkg.sv | 14 +
 rtl/register_file_sb_if.sv | 34 +++
 rtl/register_file_sb_scoreboard.sv | 48 ++++
 rtl/register_file_sb.sv | 75 +++++++
 tb/tb_register_file_sb.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Purely declarative; no timing and no flow control.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    // Architectural zero register: reads 0, never written, never busy.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/issue/writeback bundle for register_file_sb; master = pipeline, slave = regfile.
// Wires only; no latency and no backpressure of its own.
interface register_file_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
);

    logic [NRD-1:0][AW-1:0]     rd_addr;
    logic [NRD-1:0][XLEN-1:0]   rd_data;
    logic [NRD-1:0]             rd_busy;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [XLEN-1:0]            wr_data;
    logic                       iss_en;
    logic [AW-1:0]              iss_addr;
    logic                       flush;
    logic                       any_busy;
    logic [NREGS-1:0][XLEN-1:0] regs_debug;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, any_busy, regs_debug
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, any_busy, regs_debug
    );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register pending-write scoreboard; busy updates one edge after issue/writeback/flush.
// No backpressure: every strobe is accepted on the edge it is presented.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             any_busy
);

    logic [NREGS-1:0] busy_nxt;

    // Priority flush > issue > writeback: a younger issue must survive an
    // older producer's writeback to the same destination.
    always_comb begin
        busy_nxt = busy;
        busy_nxt[ZERO_REG] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign any_busy = |busy;

endmodule

// File: rtl/register_file_sb.sv
// Register file with NRD combinational read ports, optional writeback bypass and busy scoreboard.
// Reads 0-cycle, write/busy visible next cycle; no backpressure, all strobes always accepted.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic                       wr_live;

    assign wr_live = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_live) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .flush    (bus.flush),
        .busy     (busy),
        .any_busy (bus.any_busy)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd_port
        logic [AW-1:0]   addr;
        logic            is_zero;
        logic            fwd;
        logic [XLEN-1:0] data;
        logic            pend;

        assign addr    = bus.rd_addr[p];
        assign is_zero = (addr == AW'(ZERO_REG));
        // wr_live already excludes x0, so forwarding never leaks into x0.
        assign fwd     = BYPASS && wr_live && (bus.wr_addr == addr);

        always_comb begin
            data = regs[addr];
            pend = busy[addr];
            if (is_zero) begin
                data = '0;
                pend = 1'b0;
            end else if (fwd) begin
                data = bus.wr_data;
                pend = 1'b0;
            end
        end

        assign bus.rd_data[p] = data;
        assign bus.rd_busy[p] = pend;
    end

    assign bus.regs_debug = regs;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: one DUT with bypass, one without, driven by identical stimulus.
module tb_register_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b1 ();
    register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b0 ();

    assign b0.rd_addr  = b1.rd_addr;
    assign b0.wr_en    = b1.wr_en;
    assign b0.wr_addr  = b1.wr_addr;
    assign b0.wr_data  = b1.wr_data;
    assign b0.iss_en   = b1.iss_en;
    assign b0.iss_addr = b1.iss_addr;
    assign b0.flush    = b1.flush;

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_nob (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b1.wr_en  = 1'b0;
        b1.iss_en = 1'b0;
        b1.flush  = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        b1.rd_addr  = '0;
        b1.wr_en    = 1'b0;
        b1.wr_addr  = '0;
        b1.wr_data  = '0;
        b1.iss_en   = 1'b0;
        b1.iss_addr = '0;
        b1.flush    = 1'b0;
        step();
        idle();

        // 1: dirty some state, then reset
        b1.wr_en = 1'b1; b1.wr_addr = 5'd5; b1.wr_data = 32'h1111_1111;
        b1.iss_en = 1'b1; b1.iss_addr = 5'd3;
        step();
        b1.wr_addr = 5'd3; b1.wr_data = 32'h2222_2222; b1.iss_addr = 5'd12;
        step();
        idle();
        rst = 1'b1;
        step();
        idle();
        b1.rd_addr[0] = 5'd5; b1.rd_addr[1] = 5'd3;
        #1;
        chk("rst_regs_zero", {31'd0, b1.regs_debug == '0}, 32'd1);
        chk("rst_rd_busy",   {30'd0, b1.rd_busy}, 32'd0);
        chk("rst_any_busy",  {31'd0, b1.any_busy}, 32'd0);
        chk("rst_rd_x5",     b1.rd_data[0], 32'd0);

        // 2: same-cycle bypass vs stored value
        b1.wr_en = 1'b1; b1.wr_addr = 5'd5; b1.wr_data = 32'hDEAD_BEEF;
        #1;
        chk("byp_same_cycle",   b1.rd_data[0], 32'hDEAD_BEEF);
        chk("nobyp_same_cycle", b0.rd_data[0], 32'd0);
        step();
        idle();
        #1;
        chk("byp_next_cycle",   b1.rd_data[0], 32'hDEAD_BEEF);
        chk("nobyp_next_cycle", b0.rd_data[0], 32'hDEAD_BEEF);

        // 3: x0 is hardwired
        b1.wr_en = 1'b1; b1.wr_addr = 5'd0; b1.wr_data = 32'h0000_1234;
        b1.iss_en = 1'b1; b1.iss_addr = 5'd0;
        b1.rd_addr[0] = 5'd0; b1.rd_addr[1] = 5'd0;
        #1;
        chk("x0_rd_same_cycle", b1.rd_data[0], 32'd0);
        step();
        idle();
        #1;
        chk("x0_rd_data",  b1.rd_data[1], 32'd0);
        chk("x0_regs",     b1.regs_debug[0], 32'd0);
        chk("x0_rd_busy",  {30'd0, b1.rd_busy}, 32'd0);
        chk("x0_any_busy", {31'd0, b1.any_busy}, 32'd0);

        // 4: issue then writeback on x7
        b1.iss_en = 1'b1; b1.iss_addr = 5'd7;
        step();
        idle();
        b1.rd_addr[0] = 5'd7;
        #1;
        chk("x7_busy",       {31'd0, b1.rd_busy[0]}, 32'd1);
        chk("x7_any_busy",   {31'd0, b1.any_busy}, 32'd1);
        b1.wr_en = 1'b1; b1.wr_addr = 5'd7; b1.wr_data = 32'h55;
        #1;
        chk("x7_wb_busy_byp", {31'd0, b1.rd_busy[0]}, 32'd0);
        chk("x7_wb_data_byp", b1.rd_data[0], 32'h55);
        chk("x7_wb_busy_nob", {31'd0, b0.rd_busy[0]}, 32'd1);
        chk("x7_wb_any_busy", {31'd0, b1.any_busy}, 32'd1);
        step();
        idle();
        #1;
        chk("x7_after_busy", {31'd0, b1.rd_busy[0]}, 32'd0);
        chk("x7_after_data", b0.rd_data[0], 32'h55);
        chk("x7_after_any",  {31'd0, b1.any_busy}, 32'd0);

        // 5: issue wins over simultaneous writeback on x9
        b1.iss_en = 1'b1; b1.iss_addr = 5'd9;
        b1.wr_en = 1'b1; b1.wr_addr = 5'd9; b1.wr_data = 32'hAA;
        step();
        idle();
        b1.rd_addr[0] = 5'd9; b1.rd_addr[1] = 5'd9;
        #1;
        chk("x9_regs",      b1.regs_debug[9], 32'hAA);
        chk("x9_busy",      {31'd0, b1.rd_busy[1]}, 32'd1);
        chk("x9_same_data", b1.rd_data[0], b1.rd_data[1] & 32'hFFFF_FFFF);
        chk("x9_port0",     b1.rd_data[0], 32'hAA);

        // 6: flush drops the same-cycle issue but still commits data
        b1.iss_en = 1'b1; b1.iss_addr = 5'd3;
        step();
        b1.iss_addr = 5'd4;
        step();
        idle();
        b1.rd_addr[0] = 5'd3; b1.rd_addr[1] = 5'd4;
        #1;
        chk("pre_flush_busy", {30'd0, b1.rd_busy}, 32'd3);
        b1.flush = 1'b1;
        b1.iss_en = 1'b1; b1.iss_addr = 5'd6;
        b1.wr_en = 1'b1; b1.wr_addr = 5'd4; b1.wr_data = 32'h44;
        step();
        idle();
        b1.rd_addr[0] = 5'd6;
        #1;
        chk("flush_any_busy", {31'd0, b1.any_busy}, 32'd0);
        chk("flush_rd_busy",  {30'd0, b1.rd_busy}, 32'd0);
        chk("flush_wr_kept",  b1.regs_debug[4], 32'h44);

        b1.iss_en = 1'b1; b1.iss_addr = 5'd3;
        b1.wr_en = 1'b1; b1.wr_addr = 5'd8; b1.wr_data = 32'h88;
        step();
        idle();
        rst = 1'b1; b1.flush = 1'b1;
        b1.wr_en = 1'b1; b1.wr_addr = 5'd10; b1.wr_data = 32'hA5A5_A5A5;
        b1.iss_en = 1'b1; b1.iss_addr = 5'd11;
        step();
        idle();
        b1.rd_addr[0] = 5'd8; b1.rd_addr[1] = 5'd3;
        #1;
        chk("rstflush_regs", {31'd0, b1.regs_debug == '0}, 32'd1);
        chk("rstflush_any",  {31'd0, b1.any_busy}, 32'd0);
        chk("rstflush_rd8",  b1.rd_data[0], 32'd0);
        chk("rstflush_busy", {30'd0, b1.rd_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
